mouse_packet_tracker: RTL
=========================

Name: mouse_packet_tracker

Overview:
Parametrised successor to the single-byte mouse decode stage. It sits between MousePS2_Controller (received_data / received_data_en) and the game logic. It assembles standard 3-byte PS/2 mouse packets with resynchronisation and an inter-byte timeout, and tracks a clamped cursor position with configurable screen bounds, sensitivity and Y orientation. It reports all three buttons as levels plus one-cycle press pulses.

Parameters:
X_WIDTH, 9, width of x_position
Y_WIDTH, 8, width of y_position
X_MAX, 319, maximum x coordinate (minimum is 0)
Y_MAX, 239, maximum y coordinate (minimum is 0)
X_INIT, 160, x_position after reset
Y_INIT, 120, y_position after reset
SHIFT, 0, sensitivity: each delta is arithmetically right-shifted by SHIFT (0..7)
Y_INVERT, 1, 1 = screen Y grows downward (position minus dy); 0 = position plus dy
TIMEOUT_CYCLES, 1000000, idle clocks allowed between bytes of one packet (20 ms at 50 MHz)

Ports:
CLOCK_50 input 1 system clock
reset input 1 asynchronous, active-high reset
received_data input 8 byte from PS/2 controller
received_data_en input 1 one-cycle strobe: received_data valid
x_position output X_WIDTH cursor x, unsigned
y_position output Y_WIDTH cursor y, unsigned
left_pressed output 1 left button level
right_pressed output 1 right button level
middle_pressed output 1 middle button level
left_click output 1 one-cycle pulse on left 0->1
right_click output 1 one-cycle pulse on right 0->1
packet_valid output 1 one-cycle pulse per completed packet
sync_error output 1 one-cycle pulse on discarded byte or timeout

Behaviour:
- Reset (async, any state): FSM to BYTE0; x_position=X_INIT, y_position=Y_INIT; all buttons 0; all pulses 0; timeout counter 0; armed=0.
- FSM states BYTE0, BYTE1, BYTE2. Advances only on received_data_en=1.
- BYTE0 handling:
  - Byte with bit3=1 is latched as the status byte; FSM goes to BYTE1.
  - Byte with bit3=0 is discarded; sync_error pulses; FSM stays in BYTE0.
  - While armed=0, byte 0xFA (ack) is discarded silently: no sync_error, FSM stays in BYTE0.
- BYTE1: latch the X byte; FSM goes to BYTE2.
- BYTE2: on the accepting edge, compute the packet and update all outputs; FSM returns to BYTE0; armed set to 1. Outputs are registered: new values are visible in the cycle after the strobe (latency 1). packet_valid pulses in that same cycle.
- Status byte fields: bit0 left, bit1 right, bit2 middle, bit4 X sign, bit5 Y sign, bit6 X overflow, bit7 Y overflow.
- Delta computation: delta = 9-bit two's complement {sign, byte}, range -256..+255. If the axis overflow bit is set, that axis delta = 0.
- Scaling: scaled delta = delta >>> SHIFT (arithmetic, rounds toward negative infinity).
- New position: computed in a signed width of max(X_WIDTH, Y_WIDTH)+2 bits. Result <0 clamps to 0; result >MAX clamps to MAX.
- Y direction: Y_INVERT=1 gives y - dy; Y_INVERT=0 gives y + dy.
- Buttons update only on packet completion. left_click / right_click pulse in the same cycle as packet_valid when the previous level was 0 and the new level is 1.
- Timeout:
  - Counter clears on every accepted strobe and holds at 0 in BYTE0.
  - In BYTE1/BYTE2 the counter increments each clock.
  - When the counter reaches TIMEOUT_CYCLES: FSM goes to BYTE0, sync_error pulses, the partial packet is dropped, and positions are unchanged.
  - If a strobe and timeout expiry occur in the same cycle, the strobe wins: the byte is accepted and no error is raised.
- Pulses never overlap within a state for the same event; each pulse is exactly one cycle wide.
- Back-to-back strobes on consecutive clocks are accepted.

Test Plan:
- Assert reset mid-packet (after 0x08, 0x10) -> x=160, y=120, buttons 0, no pulses; next 0x08,0x02,0x00 -> x=162, y=120.
- Bytes 0x09,0x05,0x03 -> one cycle after third strobe: x=165, y=117, left_pressed=1; packet_valid and left_click high exactly 1 cycle; repeat the same packet -> x=170, left_click stays 0.
- Bytes 0x18,0x00,0x00 (dx=-256) -> x=0 (clamped). Then 0x08,0xFF,0x00 -> x=255. Then 0x08,0x7F,0x00 -> x=319 (clamped). Then 0x28,0x00,0x80 with Y_INVERT=1 (dy=-128) -> y=239 clamp from 120.
- Ack and sync handling: 0xFA after reset -> ignored, no sync_error. Then 0x05 -> sync_error 1 cycle, still BYTE0. Then 0x08,0x01,0x00 -> x=161. Then 0xFA as a status byte -> accepted (armed=1), starts a packet.
- TIMEOUT_CYCLES=100: send 0x08,0x10, idle 100 clocks -> sync_error pulse, no position change. Then 0x08,0x02,0x00 -> x=162. Also drive a strobe exactly on the expiry cycle -> byte accepted, no sync_error.
- Bytes 0x48,0x50,0x10 (X overflow) -> x unchanged, y=104. With SHIFT=2: 0x08,0x0B,0x00 -> x+2; 0x18,0xF5,0x00 (dx=-11) -> x-3.

Source files
------------

// File: rtl/mouse_packet_tracker.sv
// mouse_packet_tracker: builds 3-byte PS/2 mouse packets from the controller's
// byte strobe and keeps a clamped cursor position, button levels and press
// pulses. A timeout between bytes drops a half-received packet.
module mouse_packet_tracker #(
  parameter int X_WIDTH        = 9,
  parameter int Y_WIDTH        = 8,
  parameter int X_MAX          = 319,
  parameter int Y_MAX          = 239,
  parameter int X_INIT         = 160,
  parameter int Y_INIT         = 120,
  parameter int SHIFT          = 0,
  parameter int Y_INVERT       = 1,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic [7:0]         received_data,
  input  logic               received_data_en,
  output logic [X_WIDTH-1:0] x_position,
  output logic [Y_WIDTH-1:0] y_position,
  output logic               left_pressed,
  output logic               right_pressed,
  output logic               middle_pressed,
  output logic               left_click,
  output logic               right_click,
  output logic               packet_valid,
  output logic               sync_error
);

  typedef enum logic [1:0] {BYTE0 = 2'd0, BYTE1 = 2'd1, BYTE2 = 2'd2} state_t;

  // Position arithmetic width: wide enough for the larger axis plus sign and carry.
  localparam int PW = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 2;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0]        TIMEOUT_LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic signed [PW-1:0] X_MAX_S       = PW'(X_MAX);
  localparam logic signed [PW-1:0] Y_MAX_S       = PW'(Y_MAX);
  localparam logic [X_WIDTH-1:0]   X_MAX_V       = X_WIDTH'(X_MAX);
  localparam logic [Y_WIDTH-1:0]   Y_MAX_V       = Y_WIDTH'(Y_MAX);
  localparam logic [X_WIDTH-1:0]   X_INIT_V      = X_WIDTH'(X_INIT);
  localparam logic [Y_WIDTH-1:0]   Y_INIT_V      = Y_WIDTH'(Y_INIT);
  localparam logic [7:0]           ACK_BYTE      = 8'hFA;

  state_t            state;
  logic [CW-1:0]     timeout_count;
  logic              armed;
  // Status byte without bit 3 (always 1 once accepted): {yovf, xovf, ysign, xsign, mid, right, left}
  logic [6:0]        status;
  logic [7:0]        x_byte;

  logic signed [PW-1:0] dx;
  logic signed [PW-1:0] dy;
  logic signed [PW-1:0] sum_x;
  logic signed [PW-1:0] sum_y;
  logic [X_WIDTH-1:0]   next_x;
  logic [Y_WIDTH-1:0]   next_y;

  // 9-bit two's complement delta, forced to zero on overflow, then scaled down.
  function automatic logic signed [PW-1:0] scaled_delta(input logic sign,
                                                       input logic [7:0] mag,
                                                       input logic ovf);
    logic signed [PW-1:0] d;
    if (ovf) begin
      d = '0;
    end else begin
      d = {{(PW-9){sign}}, sign, mag};
    end
    return d >>> SHIFT;
  endfunction

  // Candidate position for the packet completing on this strobe, clamped to the screen.
  always_comb begin
    dx    = scaled_delta(status[3], x_byte, status[5]);
    dy    = scaled_delta(status[4], received_data, status[6]);
    sum_x = $signed({{(PW-X_WIDTH){1'b0}}, x_position}) + dx;
    if (Y_INVERT != 0) begin
      sum_y = $signed({{(PW-Y_WIDTH){1'b0}}, y_position}) - dy;
    end else begin
      sum_y = $signed({{(PW-Y_WIDTH){1'b0}}, y_position}) + dy;
    end
    if (sum_x[PW-1]) begin
      next_x = '0;
    end else if (sum_x > X_MAX_S) begin
      next_x = X_MAX_V;
    end else begin
      next_x = sum_x[X_WIDTH-1:0];
    end
    if (sum_y[PW-1]) begin
      next_y = '0;
    end else if (sum_y > Y_MAX_S) begin
      next_y = Y_MAX_V;
    end else begin
      next_y = sum_y[Y_WIDTH-1:0];
    end
  end

  // Packet FSM, timeout counter and all registered outputs.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state          <= BYTE0;
      timeout_count  <= '0;
      armed          <= 1'b0;
      status         <= 7'd0;
      x_byte         <= 8'd0;
      x_position     <= X_INIT_V;
      y_position     <= Y_INIT_V;
      left_pressed   <= 1'b0;
      right_pressed  <= 1'b0;
      middle_pressed <= 1'b0;
      left_click     <= 1'b0;
      right_click    <= 1'b0;
      packet_valid   <= 1'b0;
      sync_error     <= 1'b0;
    end else begin
      packet_valid <= 1'b0;
      sync_error   <= 1'b0;
      left_click   <= 1'b0;
      right_click  <= 1'b0;
      case (state)
        BYTE0: begin
          timeout_count <= '0;
          if (received_data_en) begin
            if (!armed && (received_data == ACK_BYTE)) begin
              state <= BYTE0;   // mouse ack before the first packet: drop quietly
            end else if (received_data[3]) begin
              status <= {received_data[7:4], received_data[2:0]};
              state  <= BYTE1;
            end else begin
              sync_error <= 1'b1;
              state      <= BYTE0;
            end
          end else begin
            state <= BYTE0;
          end
        end
        BYTE1: begin
          if (received_data_en) begin
            x_byte        <= received_data;
            timeout_count <= '0;
            state         <= BYTE2;
          end else if (timeout_count == TIMEOUT_LIMIT) begin
            timeout_count <= '0;
            sync_error    <= 1'b1;
            state         <= BYTE0;
          end else begin
            timeout_count <= timeout_count + CW'(1);
          end
        end
        BYTE2: begin
          if (received_data_en) begin
            x_position     <= next_x;
            y_position     <= next_y;
            left_pressed   <= status[0];
            right_pressed  <= status[1];
            middle_pressed <= status[2];
            left_click     <= status[0] & ~left_pressed;
            right_click    <= status[1] & ~right_pressed;
            packet_valid   <= 1'b1;
            armed          <= 1'b1;
            timeout_count  <= '0;
            state          <= BYTE0;
          end else if (timeout_count == TIMEOUT_LIMIT) begin
            timeout_count <= '0;
            sync_error    <= 1'b1;
            state         <= BYTE0;
          end else begin
            timeout_count <= timeout_count + CW'(1);
          end
        end
        default: begin
          timeout_count <= '0;
          state         <= BYTE0;
        end
      endcase
    end
  end

endmodule
